wide_add_sequencer: RTL and testbench

- Multi-cycle controller that computes W = N*K bit add/subtract by reusing one N-bit ripple-carry Adder instance, one N-bit chunk per cycle, LSB chunk first.
- Carry is registered between chunks.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency (K cycles) for area versus a full W-bit adder.

---
 rtl/wide_add_sequencer_pkg.sv | 14 +
 rtl/wide_add_sequencer_adder.sv | 25 ++
 rtl/wide_add_sequencer.sv | 112 +++++++++++
 tb/tb_wide_add_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the chunked wide add/subtract sequencer:
// FSM state encoding and default chunk geometry.
package wide_add_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_N = 32;
   localparam int DEFAULT_K = 4;

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// N-bit ripple-carry adder; the single shared datapath element that the
// sequencer time-multiplexes across operand chunks.
module wide_add_sequencer_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] c;

   always_comb begin
      c[0] = ci;
      for (int i = 0; i < N; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// W = N*K bit add/subtract computed one N-bit chunk per cycle, LSB first,
// with the carry registered between chunks and valid/ready on both sides.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int K = DEFAULT_K
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*K-1:0] a_in,
   input  logic [N*K-1:0] b_in,
   input  logic           cin,
   input  logic           sub,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*K-1:0] sum,
   output logic           cout,
   output logic           ovf,
   output logic           busy,
   output state_t         state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; producers hold data stable while valid=1 and ready=0.

   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   state_t              state, state_nxt;
   logic [IW-1:0]       idx;
   logic                carry_q;
   logic [K-1:0][N-1:0] op_a, op_b, sum_q;
   logic                cout_q, ovf_q;

   logic [N-1:0]        add_a, add_b, add_s;
   logic                add_co, msb_cin;

   assign add_a = op_a[idx];
   assign add_b = op_b[idx];

   wide_add_sequencer_adder #(.N(N)) u_adder (
      .a  (add_a),
      .b  (add_b),
      .ci (carry_q),
      .s  (add_s),
      .co (add_co)
   );

   // Carry into the top bit, recovered from the top chunk's sum bit.
   assign msb_cin = add_a[N-1] ^ add_b[N-1] ^ add_s[N-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)      state_nxt = RUN;
         RUN:     if (idx == LAST)   state_nxt = DONE;
         DONE:    if (out_ready)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         carry_q <= 1'b0;
         op_a    <= '0;
         op_b    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a    <= a_in;
                  op_b    <= sub ? ~b_in : b_in;
                  carry_q <= sub | cin;
                  idx     <= '0;
               end
            end
            RUN: begin
               sum_q[idx] <= add_s;
               carry_q    <= add_co;
               if (idx == LAST) begin
                  cout_q <= add_co;
                  ovf_q  <= add_co ^ msb_cin;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer at N=8, K=4: directed vectors, backpressure,
// busy-side requests, mid-run reset, issue interval and random traffic.
module tb_wide_add_sequencer;
   import wide_add_sequencer_pkg::*;

   localparam int N = 8;
   localparam int K = 4;
   localparam int W = N * K;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         in_ready, out_valid, cout, ovf, busy;
   logic [W-1:0] sum;
   state_t       state_dbg;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [W+1:0] exp_q[$];

   wide_add_sequencer #(.N(N), .K(K)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, bench did not finish");
      $fatal(1);
   end

   // Reference: full-width arithmetic, returns {cout, ovf, sum}.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic sb);
      logic [W-1:0] bb;
      logic [W:0]   r;
      logic         v;
      bb = sb ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      return {r[W], v, r[W-1:0]};
   endfunction

   // Issue one request from a negedge; returns after the negedge where out_valid
   // is seen (or the cycle budget runs out). lat counts edges after acceptance.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sb, output int lat, output int t_acc);
      a_in = a; b_in = b; cin = ci; sub = sb; in_valid = 1'b1;
      t_acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if ({cout, ovf, sum} !== '0) begin bad++; $display("FAIL reset_result got=%b/%b/%h exp=0/0/0", cout, ovf, sum); end
      total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] ta[5] = '{32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF, 32'h00FF00FF, 32'h80000000};
      logic [W-1:0] tb[5] = '{32'h00000001, 32'h00000007, 32'h00000001, 32'h00010001, 32'h00000001};
      logic         tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic         ts[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [W+1:0] e;
      int lat, t;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(model(ta[i], tb[i], tc[i], ts[i]));
         send(ta[i], tb[i], tc[i], ts[i], lat, t);
         e = exp_q.pop_front();
         total++; if (lat !== K) begin bad++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, K); end
         total++; if ({cout, ovf, sum} !== e) begin
            bad++; $display("FAIL directed_result[%0d] got=%b/%b/%h exp=%b/%b/%h", i, cout, ovf, sum, e[W+1], e[W], e[W-1:0]);
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      logic [W+1:0] e;
      int lat, t;
      e = model(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      send(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat, t);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (out_valid !== 1'b1 || {cout, ovf, sum} !== e) begin
            bad++; $display("FAIL backpressure_hold[%0d] valid=%b got=%h exp=%h", i, out_valid, sum, e[W-1:0]);
         end
      end
      release_out();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL backpressure_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_busy_ignore();
      logic [W+1:0] e;
      int lat, n_extra;
      e = model(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 1'b0);
      a_in = 32'hA5A5A5A5; b_in = 32'h0F0F0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a_in = $urandom; b_in = $urandom; sub = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      total++; if (lat !== K) begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", lat, K); end
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || {cout, ovf, sum} !== e) begin
         bad++; $display("FAIL busy_result valid=%b got=%h exp=%h", out_valid, sum, e[W-1:0]);
      end
      release_out();
      n_extra = 0;
      repeat (6) begin
         if (out_valid !== 1'b0) n_extra++;
         @(negedge clk);
      end
      total++; if (n_extra !== 0) begin bad++; $display("FAIL busy_no_second_result got=%0d exp=0", n_extra); end
   endtask

   task automatic test_reset_mid();
      logic [W+1:0] e;
      int lat, t;
      a_in = 32'hDEADBEEF; b_in = 32'h01234567; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_mid out_valid=%b sum=%h in_ready=%b busy=%b exp=0/0/1/0", out_valid, sum, in_ready, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      e = model(32'h1, 32'h1, 1'b0, 1'b0);
      send(32'h1, 32'h1, 1'b0, 1'b0, lat, t);
      total++; if (lat !== K || {cout, ovf, sum} !== e) begin
         bad++; $display("FAIL reset_recover lat=%0d got=%h exp_lat=%0d exp=%h", lat, sum, K, e[W-1:0]);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      int lat, t, t_prev;
      logic [W-1:0] a, b;
      logic [W+1:0] e;
      t_prev = -1;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom;
         exp_q.push_back(model(a, b, 1'b0, 1'b0));
         send(a, b, 1'b0, 1'b0, lat, t);
         e = exp_q.pop_front();
         total++; if ({cout, ovf, sum} !== e) begin bad++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, sum, e[W-1:0]); end
         if (t_prev >= 0) begin
            total++; if (t - t_prev !== K + 2) begin bad++; $display("FAIL b2b_interval[%0d] got=%0d exp=%0d", i, t - t_prev, K + 2); end
         end
         t_prev = t;
         release_out();
      end
   endtask

   task automatic test_random();
      int lat, t, hold;
      logic [W-1:0] a, b;
      logic ci, sb;
      logic [W+1:0] e;
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom;
         if (i % 5 == 0) b = a;
         ci = 1'($urandom_range(0, 1));
         sb = 1'($urandom_range(0, 1));
         hold = $urandom_range(0, 2);
         exp_q.push_back(model(a, b, ci, sb));
         send(a, b, ci, sb, lat, t);
         repeat (hold) @(negedge clk);
         e = exp_q.pop_front();
         total++; if (lat !== K || {cout, ovf, sum} !== e) begin
            bad++; $display("FAIL random[%0d] lat=%0d got=%b/%b/%h exp=%b/%b/%h", i, lat, cout, ovf, sum, e[W+1], e[W], e[W-1:0]);
         end
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
